// File: rtl/cache_pkg.sv
// Shared constants for the cache lookup pipeline: status-bit layout and
// default geometry used by the hit stage and its victim selector.
package cache_pkg;

  localparam int unsigned VALID_BIT_IDX       = 0;
  localparam int unsigned USE_BIT_IDX         = 1;
  localparam int unsigned STATUS_BITS_PER_WAY = 2;

  localparam int unsigned DEF_NUM_WAYS    = 4;
  localparam int unsigned DEF_TAG_BITS    = 8;
  localparam int unsigned DEF_SET_BITS    = 4;
  localparam int unsigned DEF_OFFSET_BITS = 4;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/cache_victim_select.sv
// Refill-way chooser: lowest invalid way first, otherwise the round-robin
// pointer, which only moves when a fully-valid set actually evicts.
module cache_victim_select
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = DEF_NUM_WAYS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_WAYS-1:0] valid_bits,
  input  logic                advance,
  output logic [NUM_WAYS-1:0] victim_blocks_c,
  output logic                all_valid_c
);

  localparam int unsigned IDX_W = $clog2(NUM_WAYS);

  logic [IDX_W-1:0]    rr_ptr_q;
  logic [NUM_WAYS-1:0] invalid_pick;
  logic                found;

  assign all_valid_c = &valid_bits;

  // Round-robin pointer, wraps after the last way
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (advance) begin
      if (rr_ptr_q == IDX_W'(NUM_WAYS - 1)) begin
        rr_ptr_q <= '0;
      end else begin
        rr_ptr_q <= rr_ptr_q + IDX_W'(1);
      end
    end
  end

  // One-hot of the lowest-index invalid way
  always_comb begin
    invalid_pick = '0;
    found        = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!valid_bits[w] && !found) begin
        invalid_pick[w] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  // Invalid ways win; a full set falls back to the pointer
  always_comb begin
    victim_blocks_c = invalid_pick;
    if (all_valid_c) begin
      victim_blocks_c = NUM_WAYS'(1) << rr_ptr_q;
    end
  end

endmodule

// File: rtl/cache_hit_stage.sv
// Single-register tag-compare stage: captures a lookup, reports hit vector,
// lowest hit index, multi-hit error and refill victim, and keeps hit/miss
// statistics counted on the output handshake.
module cache_hit_stage
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS    = DEF_NUM_WAYS,
  parameter int unsigned TAG_BITS    = DEF_TAG_BITS,
  parameter int unsigned SET_BITS    = DEF_SET_BITS,
  parameter int unsigned OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_valid,
  output logic                                    o_ready,
  input  logic [TAG_BITS-1:0]                     i_tag_bits,
  input  logic [NUM_WAYS*TAG_BITS-1:0]            i_tag_array_tag_data,
  input  logic [STATUS_BITS_PER_WAY*NUM_WAYS-1:0] i_status_array_data,
  input  logic [SET_BITS-1:0]                     i_set_bits,
  input  logic [OFFSET_BITS-1:0]                  i_block_offset_bits,
  input  logic                                    i_ready,
  input  logic                                    i_clear_counts,
  output logic                                    o_valid,
  output logic [NUM_WAYS-1:0]                     o_hit_blocks,
  output logic [$clog2(NUM_WAYS)-1:0]             o_hit_idx,
  output logic                                    o_cache_hit,
  output logic                                    o_multi_hit,
  output logic [NUM_WAYS-1:0]                     o_victim_blocks,
  output logic [TAG_BITS-1:0]                     o_tag_bits,
  output logic [SET_BITS-1:0]                     o_set_bits,
  output logic [OFFSET_BITS-1:0]                  o_block_offset_bits,
  output logic [STATUS_BITS_PER_WAY*NUM_WAYS-1:0] o_status_array_data,
  output logic [CNT_W-1:0]                        o_hit_count,
  output logic [CNT_W-1:0]                        o_miss_count
);

  localparam int unsigned IDX_W = $clog2(NUM_WAYS);
  localparam int unsigned STS_W = STATUS_BITS_PER_WAY * NUM_WAYS;

  logic                         valid_q;
  logic [TAG_BITS-1:0]          tag_q;
  logic [NUM_WAYS*TAG_BITS-1:0] tag_array_q;
  logic [STS_W-1:0]             status_q;
  logic [SET_BITS-1:0]          set_q;
  logic [OFFSET_BITS-1:0]       offset_q;
  logic [CNT_W-1:0]             hit_cnt_q;
  logic [CNT_W-1:0]             miss_cnt_q;

  logic [NUM_WAYS-1:0] way_valid;
  logic [NUM_WAYS-1:0] hit_blocks;
  logic [IDX_W-1:0]    hit_idx;
  logic                hit_found;
  logic                cache_hit;
  logic                capture;
  logic                drain;
  logic                rr_advance;
  logic [NUM_WAYS-1:0] victim_c;
  logic                all_valid_c;

  assign o_ready = ~valid_q | i_ready;
  assign capture = i_valid & o_ready;
  assign drain   = valid_q & i_ready;

  // Stage register: load on accept, empty on drain without a refill
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      tag_q       <= '0;
      tag_array_q <= '0;
      status_q    <= '0;
      set_q       <= '0;
      offset_q    <= '0;
    end else if (capture) begin
      valid_q     <= 1'b1;
      tag_q       <= i_tag_bits;
      tag_array_q <= i_tag_array_tag_data;
      status_q    <= i_status_array_data;
      set_q       <= i_set_bits;
      offset_q    <= i_block_offset_bits;
    end else if (drain) begin
      valid_q     <= 1'b0;
    end
  end

  // Per-way tag compare qualified by the way's valid bit and stage valid
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign way_valid[w]  = status_q[w*STATUS_BITS_PER_WAY + VALID_BIT_IDX];
    assign hit_blocks[w] = valid_q & way_valid[w]
                         & (tag_array_q[w*TAG_BITS +: TAG_BITS] == tag_q);
  end

  // Lowest hitting way index, 0 when nothing hits
  always_comb begin
    hit_idx   = '0;
    hit_found = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (hit_blocks[w] && !hit_found) begin
        hit_idx   = IDX_W'(w);
        hit_found = 1'b1;
      end
    end
  end

  assign cache_hit  = |hit_blocks;
  assign rr_advance = drain & ~cache_hit & all_valid_c;

  cache_victim_select #(
    .NUM_WAYS (NUM_WAYS)
  ) u_victim (
    .clk             (clk),
    .rst             (rst),
    .valid_bits      (way_valid),
    .advance         (rr_advance),
    .victim_blocks_c (victim_c),
    .all_valid_c     (all_valid_c)
  );

  // Saturating statistics; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || i_clear_counts) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (drain) begin
      if (cache_hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_valid             = valid_q;
  assign o_hit_blocks        = hit_blocks;
  assign o_hit_idx           = hit_idx;
  assign o_cache_hit         = cache_hit;
  assign o_multi_hit         = |(hit_blocks & (hit_blocks - NUM_WAYS'(1)));
  assign o_victim_blocks     = (valid_q & ~cache_hit) ? victim_c : '0;
  assign o_tag_bits          = tag_q;
  assign o_set_bits          = set_q;
  assign o_block_offset_bits = offset_q;
  assign o_status_array_data = status_q;
  assign o_hit_count         = hit_cnt_q;
  assign o_miss_count        = miss_cnt_q;

endmodule

// File: tb/tb_cache_hit_stage.sv
// Directed bench for cache_hit_stage with 4 ways, 8-bit tags, 2-bit counters.
module tb_cache_hit_stage;

  localparam int unsigned NW = 4;
  localparam int unsigned TB = 8;
  localparam int unsigned SB = 4;
  localparam int unsigned OB = 4;
  localparam int unsigned CW = 2;

  logic            clk;
  logic            rst;
  logic            i_valid;
  logic            o_ready;
  logic [TB-1:0]   i_tag_bits;
  logic [NW*TB-1:0] i_tag_array_tag_data;
  logic [2*NW-1:0] i_status_array_data;
  logic [SB-1:0]   i_set_bits;
  logic [OB-1:0]   i_block_offset_bits;
  logic            i_ready;
  logic            i_clear_counts;
  logic            o_valid;
  logic [NW-1:0]   o_hit_blocks;
  logic [1:0]      o_hit_idx;
  logic            o_cache_hit;
  logic            o_multi_hit;
  logic [NW-1:0]   o_victim_blocks;
  logic [TB-1:0]   o_tag_bits;
  logic [SB-1:0]   o_set_bits;
  logic [OB-1:0]   o_block_offset_bits;
  logic [2*NW-1:0] o_status_array_data;
  logic [CW-1:0]   o_hit_count;
  logic [CW-1:0]   o_miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  cache_hit_stage #(
    .NUM_WAYS(NW), .TAG_BITS(TB), .SET_BITS(SB), .OFFSET_BITS(OB), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_tag_bits(i_tag_bits), .i_tag_array_tag_data(i_tag_array_tag_data),
    .i_status_array_data(i_status_array_data), .i_set_bits(i_set_bits),
    .i_block_offset_bits(i_block_offset_bits), .i_ready(i_ready),
    .i_clear_counts(i_clear_counts), .o_valid(o_valid),
    .o_hit_blocks(o_hit_blocks), .o_hit_idx(o_hit_idx),
    .o_cache_hit(o_cache_hit), .o_multi_hit(o_multi_hit),
    .o_victim_blocks(o_victim_blocks), .o_tag_bits(o_tag_bits),
    .o_set_bits(o_set_bits), .o_block_offset_bits(o_block_offset_bits),
    .o_status_array_data(o_status_array_data),
    .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [TB-1:0] tag, input logic [NW*TB-1:0] tags,
                           input logic [2*NW-1:0] sts, input logic [SB-1:0] set,
                           input logic [OB-1:0] off);
    i_valid              = 1'b1;
    i_tag_bits           = tag;
    i_tag_array_tag_data = tags;
    i_status_array_data  = sts;
    i_set_bits           = set;
    i_block_offset_bits  = off;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    i_ready = 1'b0;
    do_reset();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_checks++; if (o_hit_count !== 2'd0 || o_miss_count !== 2'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", o_hit_count, o_miss_count); end
    n_checks++; if (o_tag_bits !== 8'h00 || o_hit_blocks !== 4'b0000) begin n_fail++; $display("FAIL reset_payload: got tag %h hits %b want 00 0000", o_tag_bits, o_hit_blocks); end
  endtask

  task automatic test_hit();
    i_ready = 1'b1;
    drive_req(8'hA5, 32'h11A52233, 8'h55, 4'h3, 4'h9);
    step();
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL hit_valid: got %b want 1", o_valid); end
    n_checks++; if (o_hit_blocks !== 4'b0100) begin n_fail++; $display("FAIL hit_blocks: got %b want 0100", o_hit_blocks); end
    n_checks++; if (o_hit_idx !== 2'd2) begin n_fail++; $display("FAIL hit_idx: got %0d want 2", o_hit_idx); end
    n_checks++; if (o_cache_hit !== 1'b1 || o_multi_hit !== 1'b0) begin n_fail++; $display("FAIL hit_flags: got hit %b multi %b want 1 0", o_cache_hit, o_multi_hit); end
    n_checks++; if (o_victim_blocks !== 4'b0000) begin n_fail++; $display("FAIL hit_victim: got %b want 0000", o_victim_blocks); end
    n_checks++; if (o_tag_bits !== 8'hA5 || o_set_bits !== 4'h3 || o_block_offset_bits !== 4'h9 || o_status_array_data !== 8'h55)
      begin n_fail++; $display("FAIL hit_passthru: got %h %h %h %h want a5 3 9 55", o_tag_bits, o_set_bits, o_block_offset_bits, o_status_array_data); end
    step();
    n_checks++; if (o_valid !== 1'b0 || o_victim_blocks !== 4'b0000) begin n_fail++; $display("FAIL hit_drain: got valid %b victim %b want 0 0000", o_valid, o_victim_blocks); end
    n_checks++; if (o_hit_count !== 2'd1 || o_miss_count !== 2'd0) begin n_fail++; $display("FAIL hit_count: got %0d/%0d want 1/0", o_hit_count, o_miss_count); end
  endtask

  task automatic test_miss();
    i_ready = 1'b1;
    drive_req(8'hA5, 32'h11A52233, 8'h45, 4'h1, 4'h2);
    step();
    i_valid = 1'b0;
    n_checks++; if (o_cache_hit !== 1'b0 || o_hit_blocks !== 4'b0000 || o_hit_idx !== 2'd0)
      begin n_fail++; $display("FAIL miss_flags: got hit %b blocks %b idx %0d want 0 0000 0", o_cache_hit, o_hit_blocks, o_hit_idx); end
    n_checks++; if (o_victim_blocks !== 4'b0100) begin n_fail++; $display("FAIL miss_victim: got %b want 0100", o_victim_blocks); end
    step();
    n_checks++; if (o_miss_count !== 2'd1 || o_hit_count !== 2'd1) begin n_fail++; $display("FAIL miss_count: got %0d/%0d want 1/1", o_hit_count, o_miss_count); end
  endtask

  task automatic test_back_to_back();
    logic [NW-1:0] exp_v [5];
    exp_v[0] = 4'b0001; exp_v[1] = 4'b0010; exp_v[2] = 4'b0100;
    exp_v[3] = 4'b1000; exp_v[4] = 4'b0001;
    do_reset();
    i_ready = 1'b1;
    drive_req(8'hFF, 32'h11A52233, 8'h55, 4'h0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++; if (o_valid !== 1'b1 || o_victim_blocks !== exp_v[k])
        begin n_fail++; $display("FAIL rr_victim_%0d: got valid %b victim %b want 1 %b", k, o_valid, o_victim_blocks, exp_v[k]); end
    end
    i_valid = 1'b0;
    step();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b want 0", o_valid); end
    n_checks++; if (o_miss_count !== 2'd3) begin n_fail++; $display("FAIL rr_miss_sat: got %0d want 3", o_miss_count); end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    drive_req(8'h01, 32'h00000001, 8'h55, 4'h3, 4'h5);
    step();
    drive_req(8'h02, 32'h00000002, 8'h55, 4'hC, 4'hA);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_tag_bits !== 8'h01 || o_set_bits !== 4'h3 || o_block_offset_bits !== 4'h5)
        begin n_fail++; $display("FAIL stall_hold_%0d: got v %b rdy %b tag %h set %h off %h want 1 0 01 3 5", k, o_valid, o_ready, o_tag_bits, o_set_bits, o_block_offset_bits); end
      step();
    end
    i_ready = 1'b1;
    #1;
    n_checks++; if (o_ready !== 1'b1 || o_tag_bits !== 8'h01) begin n_fail++; $display("FAIL stall_first_out: got rdy %b tag %h want 1 01", o_ready, o_tag_bits); end
    step();
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b1 || o_tag_bits !== 8'h02 || o_set_bits !== 4'hC)
      begin n_fail++; $display("FAIL stall_second_out: got v %b tag %h set %h want 1 02 c", o_valid, o_tag_bits, o_set_bits); end
    step();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_dup: got %b want 0", o_valid); end
  endtask

  task automatic test_multi_hit();
    i_ready = 1'b1;
    drive_req(8'h7E, 32'h7E007E00, 8'h55, 4'h0, 4'h0);
    step();
    i_valid = 1'b0;
    n_checks++; if (o_hit_blocks !== 4'b1010 || o_hit_idx !== 2'd1) begin n_fail++; $display("FAIL multi_blocks: got %b idx %0d want 1010 1", o_hit_blocks, o_hit_idx); end
    n_checks++; if (o_multi_hit !== 1'b1 || o_cache_hit !== 1'b1) begin n_fail++; $display("FAIL multi_flags: got multi %b hit %b want 1 1", o_multi_hit, o_cache_hit); end
    step();
  endtask

  task automatic test_counters();
    do_reset();
    i_ready = 1'b1;
    drive_req(8'hA5, 32'h11A52233, 8'h55, 4'h0, 4'h0);
    step(); step(); step();
    n_checks++; if (o_hit_count !== 2'd2) begin n_fail++; $display("FAIL cnt_two: got %0d want 2", o_hit_count); end
    step(); step();
    n_checks++; if (o_hit_count !== 2'd3) begin n_fail++; $display("FAIL cnt_sat: got %0d want 3", o_hit_count); end
    i_valid = 1'b0;
    i_clear_counts = 1'b1;
    step();
    i_clear_counts = 1'b0;
    n_checks++; if (o_hit_count !== 2'd0 || o_miss_count !== 2'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d/%0d want 0/0", o_hit_count, o_miss_count); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL cnt_drain: got %b want 0", o_valid); end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    drive_req(8'hA5, 32'h11A52233, 8'h55, 4'h7, 4'h7);
    step();
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_held: got %b want 1", o_valid); end
    do_reset();
    n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_set_bits !== 4'h0)
      begin n_fail++; $display("FAIL mid_reset: got v %b rdy %b set %h want 0 1 0", o_valid, o_ready, o_set_bits); end
    i_ready = 1'b1;
    step();
    n_checks++; if (o_hit_count !== 2'd0 || o_miss_count !== 2'd0) begin n_fail++; $display("FAIL mid_uncounted: got %0d/%0d want 0/0", o_hit_count, o_miss_count); end
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_clear_counts = 1'b0;
    i_tag_bits = '0;
    i_tag_array_tag_data = '0;
    i_status_array_data = '0;
    i_set_bits = '0;
    i_block_offset_bits = '0;
    test_reset();
    test_hit();
    test_miss();
    test_back_to_back();
    test_backpressure();
    test_multi_hit();
    test_counters();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_hit_stage.md
CACHE_HIT_STAGE -- requirements
Module: cache_hit_stage

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, meaning number of ways per set (power of two, 2..16).
REQ-002 SHALL have parameter TAG_BITS, default 8, meaning tag width per way.
REQ-003 SHALL have parameter SET_BITS, default 4, meaning set index width.
REQ-004 SHALL have parameter OFFSET_BITS, default 4, meaning block offset width.
REQ-005 SHALL have parameter CNT_W, default 16, meaning width of each hit/miss counter.
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports (name  direction  width  meaning):
- i_valid  in  1  upstream request valid
- o_ready  out  1  stage can accept
- i_tag_bits  in  TAG_BITS  lookup tag
- i_tag_array_tag_data  in  NUM_WAYS*TAG_BITS  way w at [w*TAG_BITS +: TAG_BITS]
- i_status_array_data  in  2*NUM_WAYS  way w: bit 2w valid, bit 2w+1 use
- i_set_bits  in  SET_BITS  pass-through
- i_block_offset_bits  in  OFFSET_BITS  pass-through
- i_ready  in  1  downstream ready
- i_clear_counts  in  1  zero both counters
- o_valid  out  1  result valid
- o_hit_blocks  out  NUM_WAYS  one-hot-or-more hit vector
- o_hit_idx  out  clog2(NUM_WAYS)  lowest hitting way
- o_cache_hit  out  1  any hit
- o_multi_hit  out  1  more than one way hit (error flag)
- o_victim_blocks  out  NUM_WAYS  one-hot refill way on miss
- o_tag_bits, o_set_bits, o_block_offset_bits, o_status_array_data  out  as inputs  registered pass-through
- o_hit_count, o_miss_count  out  CNT_W  statistics

Function
REQ-008 SHALL drive o_ready = ~o_valid | i_ready (single register stage, full throughput, no combinational i_valid->o_ready path).
REQ-009 SHALL capture all inputs into the stage register on i_valid & o_ready; latency one cycle to o_valid.
REQ-010 SHALL hold all payload outputs stable while o_valid & ~i_ready.
REQ-011 SHALL clear o_valid on o_valid & i_ready when no new capture occurs in the same cycle; simultaneous capture and drain keeps o_valid=1 with new data.
REQ-012 SHALL set hit bit w = (registered tag == way w tag) & way w valid bit, all masked by o_valid.
REQ-013 SHALL drive o_cache_hit = OR of o_hit_blocks; o_hit_idx = lowest set index, 0 when no hit.
REQ-014 SHALL assert o_multi_hit when two or more hit bits are set; o_cache_hit stays 1.
REQ-015 SHALL on o_valid & miss select victim: lowest-index invalid way; if all valid, way at round-robin pointer rr_ptr; o_victim_blocks=0 on hit or ~o_valid.
REQ-016 SHALL advance rr_ptr by one (wrap NUM_WAYS-1 -> 0) only on an output handshake that is a miss with all ways valid.
REQ-017 SHALL increment o_hit_count or o_miss_count on each output handshake (o_valid & i_ready), saturating at 2^CNT_W-1.
REQ-018 SHALL give i_clear_counts priority over a same-cycle increment (result 0).

Reset
REQ-019 SHALL on rst set o_valid=0, all payload registers=0, rr_ptr=0, both counters=0; o_ready=1 in the cycle after.
REQ-020 SHALL on rst mid-operation discard any held entry without a handshake and without counting it.

Structure
REQ-021 SHALL take VALID_BIT_IDX=0, USE_BIT_IDX=1, STATUS_BITS_PER_WAY=2 and default parameter values from shared package cache_pkg.
REQ-022 SHALL place invalid-priority selection and rr_ptr in sub-module cache_victim_select.

Verification (NUM_WAYS=4, TAG_BITS=8)
REQ-023 SHALL cover: tag 0xA5, tags 0x11A52233, status 0x55 -> next cycle hit_blocks 0100, hit_idx 2, cache_hit 1, victim 0000.
REQ-024 SHALL cover: same with status 0x45 -> miss, victim 0100.
REQ-025 SHALL cover: five all-valid misses after reset -> victims 0001,0010,0100,1000,0001.
REQ-026 SHALL cover: i_ready=0 for 3 cycles with two requests -> o_ready=0, outputs stable, both delivered in order, none lost or duplicated.
REQ-027 SHALL cover: ways 1 and 3 tag 0x7E, valid, lookup 0x7E -> hit_blocks 1010, hit_idx 1, multi_hit 1.
REQ-028 SHALL cover: CNT_W=2, 5 hits -> o_hit_count 3; i_clear_counts with a hit -> 0.
